vertex_op_scheduler: RTL and testbench
======================================

# vertex_op_scheduler

Two-port command scheduler in front of the `vertexops` transform unit. It accepts `{op, vector}` commands from two requesters, for example the host command queue and the display-list replay engine, over valid/ready handshakes. It arbitrates round-robin and drives one registered command per cycle into the datapath's `op`/`vectorIn`, honouring the datapath `stall`. Because the state matrix is shared, a requester that issues PUSHMATRIX holds exclusive ownership until its matching POPMATRIX.

## Interface
Parameters:
- `STACK_DEPTH`, default 16: matrix stack capacity; bounds the nesting counter.
- `DEPTH_W`, default 5: width of the nesting counter; must satisfy 2^DEPTH_W > STACK_DEPTH.

Ports:
- `CLK`  in  1  single clock, rising edge.
- `RST_N`  in  1  reset, asynchronous assert, active-low.
- `REQ0_VALID` / `REQ1_VALID`  in  1  requester command valid.
- `REQ0_OP` / `REQ1_OP`  in  4  op code, same encoding as `vertexops`.
- `REQ0_VECTOR` / `REQ1_VECTOR`  in  64  command operand.
- `REQ0_READY` / `REQ1_READY`  out  1  command accepted on this edge.
- `STALL`  in  1  datapath stall; the same net feeds `vertexops.stall`.
- `OP`  out  4  registered op to `vertexops.op`.
- `VECTOR`  out  64  registered operand to `vertexops.vectorIn`.
- `GRANT`  out  2  one-hot current owner; 00 when idle.
- `LOCKED`  out  1  ownership lock held.
- `NEST_DEPTH`  out  DEPTH_W  current push nesting depth.
- `ERR`  out  1  sticky protocol error.
- `VERTEX_COUNT`  out  32  SETVERTEX commands issued (see Configuration).

## Operation
- Op encoding: NOP 0, SETVERTEX 1, COLOR 2, ROTATE 3, TRANSLATE 4, SCALE 5, PUSHMATRIX 6, POPMATRIX 7, LOADIDENTITY 8. Codes 9–15 are illegal.
- States: UNLOCKED and LOCKED(owner).
- **UNLOCKED arbitration:**
  - If exactly one requester is valid, it is granted.
  - If both are valid, the requester not served last is granted. The round-robin pointer favours REQ0 after reset.
  - The pointer updates only on an accept.
- **LOCKED:** only the owner is granted. The other requester sees READY=0 even if the owner's VALID is low.
- **Accept:** `REQx_READY = grant_x & REQx_VALID & ~STALL`. On an accept edge, OP/VECTOR load the command (after the substitutions below).
- **No accept, STALL=0:** OP loads NOP; VECTOR holds its value.
- **STALL=1:** OP/VECTOR and all state hold.
- **PUSHMATRIX accepted:**
  - If depth < STACK_DEPTH: depth increments and the lock is set to the issuer; the lock transition happens on the same edge.
  - If depth == STACK_DEPTH: forwarded as NOP, ERR is set, and depth and lock are unchanged.
- **POPMATRIX accepted:**
  - If depth > 0: depth decrements. On reaching 0 the lock releases and the pointer moves to the other requester.
  - If depth == 0: forwarded as NOP and ERR is set.
- **Illegal op accepted:** forwarded as NOP; ERR is set.
- ERR clears only on reset.
- **Reset (any time, including mid-lock):** OP=NOP, VECTOR=0, GRANT=00, LOCKED=0, NEST_DEPTH=0, ERR=0, VERTEX_COUNT=0, pointer=REQ0. An in-flight command is dropped.

## Timing
- READY is combinational from VALID, the lock/pointer state, and STALL. No combinational path exists from READY back to VALID.
- **Latency:** a command accepted at edge N appears on OP at N+1. `vertexops` consumes it at the first edge ≥ N+1 where STALL=0.
- **Throughput:** one command per cycle with STALL low.
- GRANT, LOCKED and NEST_DEPTH are registered and reflect the state after the last edge.
- A lock takes effect on the accepting edge, so the other requester cannot interleave on the very next cycle.

## Configuration
- `VSCHED_VERTEX_COUNT_EN` defined: VERTEX_COUNT is a 32-bit counter that increments on each accepted SETVERTEX, wraps from 0xFFFFFFFF to 0, and resets to 0.
- `VSCHED_VERTEX_COUNT_EN` undefined: the counter is not built and VERTEX_COUNT is tied to 0. The port list is unchanged.

## Structure
- Package `vsched_pkg`:
  - op-code localparams (NOP…LOADIDENTITY);
  - `vsched_op_t` 4-bit typedef;
  - a legal-op check function.
- The op encoding in `vsched_pkg` is shared with `vertexops`.
- One sub-module, `vsched_rr_arbiter`: a 2-way round-robin arbiter with a lock/force-owner input, returning the one-hot grant. The top level holds the lock FSM, depth counter, output register, ERR and the counter.

## Test plan
- REQ0 and REQ1 both valid with SETVERTEX, STALL=0, from reset → accepts alternate 0,1,0,1; OP=1 each cycle with VECTOR from the granted port; VERTEX_COUNT=4 after 4 cycles when the macro is defined.
- REQ1 issues PUSH, TRANSLATE(X=5), SETVERTEX, POP while REQ0 is continuously valid → REQ0_READY=0 from the PUSH-accept edge until the POP-accept edge; LOCKED=1 and NEST_DEPTH=1 during the sequence; REQ0 is granted on the cycle after the POP.
- REQ0 issues 17 PUSHes with STACK_DEPTH=16 → NEST_DEPTH saturates at 16; the 17th is forwarded as OP=0 and ERR=1.
- POP with NEST_DEPTH=0 → OP=0, ERR=1, LOCKED=0.
- STALL held high for 3 cycles with SETVERTEX pending → READY=0 and OP/VECTOR stable for 3 cycles; accepted on the first edge after STALL falls.
- RST_N pulsed low while LOCKED with NEST_DEPTH=2 → all outputs go to their reset values asynchronously; after release, REQ1 alone is granted immediately.

Source files
------------

// File: rtl/vsched_pkg.sv
// Shared definitions for the vertex op scheduler: op encoding (common with vertexops),
// the op type, a legality check and the ownership-lock state type.
package vsched_pkg;

  typedef logic [3:0] vsched_op_t;

  localparam vsched_op_t OP_NOP          = 4'd0;
  localparam vsched_op_t OP_SETVERTEX    = 4'd1;
  localparam vsched_op_t OP_COLOR        = 4'd2;
  localparam vsched_op_t OP_ROTATE       = 4'd3;
  localparam vsched_op_t OP_TRANSLATE    = 4'd4;
  localparam vsched_op_t OP_SCALE        = 4'd5;
  localparam vsched_op_t OP_PUSHMATRIX   = 4'd6;
  localparam vsched_op_t OP_POPMATRIX    = 4'd7;
  localparam vsched_op_t OP_LOADIDENTITY = 4'd8;

  typedef enum logic {
    StUnlocked,
    StLocked
  } lock_state_t;

  // Codes above LOADIDENTITY are not understood by vertexops.
  function automatic logic vsched_op_legal(vsched_op_t op);
    return op <= OP_LOADIDENTITY;
  endfunction

endpackage

// File: rtl/vsched_rr_arbiter.sv
// 2-way round-robin arbiter. While lock_i is set the owner is granted unconditionally,
// so the other requester stays shut out even when the owner is momentarily idle.
module vsched_rr_arbiter (
  input  logic [1:0] valid_i,
  input  logic       ptr_i,    // requester favoured when both are valid
  input  logic       lock_i,
  input  logic       owner_i,
  output logic [1:0] gnt_o
);

  // One-hot grant selection
  always_comb begin
    gnt_o = 2'b00;
    if (lock_i) begin
      gnt_o = owner_i ? 2'b10 : 2'b01;
    end else begin
      unique case (valid_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = ptr_i ? 2'b10 : 2'b01;
        default: gnt_o = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/vertex_op_scheduler.sv
// Two-port command scheduler in front of vertexops. Round-robin between two requesters,
// with exclusive ownership from PUSHMATRIX until the matching POPMATRIX.
// Optional feature: define VSCHED_VERTEX_COUNT_EN to build the SETVERTEX counter.
module vertex_op_scheduler
  import vsched_pkg::*;
#(
  parameter int unsigned STACK_DEPTH = 16,
  parameter int unsigned DEPTH_W     = 5
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               REQ0_VALID,
  input  logic [3:0]         REQ0_OP,
  input  logic [63:0]        REQ0_VECTOR,
  output logic               REQ0_READY,
  input  logic               REQ1_VALID,
  input  logic [3:0]         REQ1_OP,
  input  logic [63:0]        REQ1_VECTOR,
  output logic               REQ1_READY,
  input  logic               STALL,
  output logic [3:0]         OP,
  output logic [63:0]        VECTOR,
  output logic [1:0]         GRANT,
  output logic               LOCKED,
  output logic [DEPTH_W-1:0] NEST_DEPTH,
  output logic               ERR,
  output logic [31:0]        VERTEX_COUNT
);

  lock_state_t        state_q, state_d;
  logic               owner_q, owner_d;
  logic               ptr_q, ptr_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  vsched_op_t         op_q, op_d;
  logic [63:0]        vec_q, vec_d;
  logic [1:0]         grant_q, grant_d;
  logic               err_q, err_d;

  logic [1:0]  gnt;
  logic        acc, acc_idx;
  vsched_op_t  acc_op;
  logic [63:0] acc_vec;

  vsched_rr_arbiter u_arb (
    .valid_i (REQ1_VALID ? {1'b1, REQ0_VALID} : {1'b0, REQ0_VALID}),
    .ptr_i   (ptr_q),
    .lock_i  (state_q == StLocked),
    .owner_i (owner_q),
    .gnt_o   (gnt)
  );

  assign REQ0_READY = gnt[0] & REQ0_VALID & ~STALL;
  assign REQ1_READY = gnt[1] & REQ1_VALID & ~STALL;
  assign acc        = REQ0_READY | REQ1_READY;
  assign acc_idx    = REQ1_READY;
  assign acc_op     = acc_idx ? REQ1_OP : REQ0_OP;
  assign acc_vec    = acc_idx ? REQ1_VECTOR : REQ0_VECTOR;

  // Next state: lock FSM, nesting depth, pointer, output register and sticky error
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    depth_d = depth_q;
    op_d    = op_q;
    vec_d   = vec_q;
    grant_d = grant_q;
    err_d   = err_q;
    if (!STALL) begin
      op_d    = OP_NOP;
      grant_d = (state_q == StLocked) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
      if (acc) begin
        op_d    = acc_op;
        vec_d   = acc_vec;
        ptr_d   = ~acc_idx;
        grant_d = acc_idx ? 2'b10 : 2'b01;
        if (!vsched_op_legal(acc_op)) begin
          op_d  = OP_NOP;
          err_d = 1'b1;
        end else if (acc_op == OP_PUSHMATRIX) begin
          if (depth_q < DEPTH_W'(STACK_DEPTH)) begin
            depth_d = depth_q + DEPTH_W'(1);
            state_d = StLocked;
            owner_d = acc_idx;
          end else begin
            op_d  = OP_NOP;
            err_d = 1'b1;
          end
        end else if (acc_op == OP_POPMATRIX) begin
          if (depth_q != '0) begin
            depth_d = depth_q - DEPTH_W'(1);
            if (depth_q == DEPTH_W'(1)) begin
              state_d = StUnlocked;
            end
          end else begin
            op_d  = OP_NOP;
            err_d = 1'b1;
          end
        end
      end
    end
  end

  // State registers; reset drops any in-flight command
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= StUnlocked;
      owner_q <= 1'b0;
      ptr_q   <= 1'b0;
      depth_q <= '0;
      op_q    <= OP_NOP;
      vec_q   <= '0;
      grant_q <= 2'b00;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      depth_q <= depth_d;
      op_q    <= op_d;
      vec_q   <= vec_d;
      grant_q <= grant_d;
      err_q   <= err_d;
    end
  end

  assign OP         = op_q;
  assign VECTOR     = vec_q;
  assign GRANT      = grant_q;
  assign LOCKED     = (state_q == StLocked);
  assign NEST_DEPTH = depth_q;
  assign ERR        = err_q;

`ifdef VSCHED_VERTEX_COUNT_EN
  logic [31:0] cnt_q, cnt_d;

  // Count accepted SETVERTEX commands, wrapping naturally
  always_comb begin
    cnt_d = cnt_q;
    if (acc && acc_op == OP_SETVERTEX) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  // Counter register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign VERTEX_COUNT = cnt_q;
`else
  assign VERTEX_COUNT = 32'd0;
`endif

endmodule

// File: tb/tb_vertex_op_scheduler.sv
// Self-checking bench for vertex_op_scheduler: directed scenarios plus randomized traffic,
// all checked against a behavioural model of the scheduling rules.
module tb_vertex_op_scheduler;

  localparam int SD = 16;
`ifdef VSCHED_VERTEX_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        v0 = 1'b0, v1 = 1'b0, stall = 1'b0;
  logic [3:0]  op0 = '0, op1 = '0;
  logic [63:0] vec0 = '0, vec1 = '0;
  logic        r0, r1, locked_o, err_o;
  logic [3:0]  op_o;
  logic [63:0] vec_o;
  logic [1:0]  grant_o;
  logic [4:0]  depth_o;
  logic [31:0] cnt_o;

  int n_tests = 0;
  int n_fail = 0;

  // Behavioural model state
  bit          m_locked;
  int          m_owner, m_depth, m_last;
  logic [3:0]  m_op;
  logic [63:0] m_vec;
  logic [1:0]  m_grant;
  bit          m_err;
  logic [31:0] m_cnt;

  always #5 clk = ~clk;

  vertex_op_scheduler #(.STACK_DEPTH(SD), .DEPTH_W(5)) dut (
    .CLK(clk), .RST_N(rst_n),
    .REQ0_VALID(v0), .REQ0_OP(op0), .REQ0_VECTOR(vec0), .REQ0_READY(r0),
    .REQ1_VALID(v1), .REQ1_OP(op1), .REQ1_VECTOR(vec1), .REQ1_READY(r1),
    .STALL(stall), .OP(op_o), .VECTOR(vec_o), .GRANT(grant_o), .LOCKED(locked_o),
    .NEST_DEPTH(depth_o), .ERR(err_o), .VERTEX_COUNT(cnt_o)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
    $fatal(1);
  end

  // Requester i may go when unstalled and either it owns the lock, or it is the only one
  // asking, or both ask and it was not the one served last.
  function automatic bit m_ready(int i);
    logic vi, vo;
    vi = (i == 1) ? v1 : v0;
    vo = (i == 1) ? v0 : v1;
    if (stall) return 1'b0;
    if (m_locked) return (m_owner == i) && vi;
    if (!vi) return 1'b0;
    if (!vo) return 1'b1;
    return m_last != i;
  endfunction

  task automatic model_reset();
    m_locked = 0; m_owner = 0; m_depth = 0; m_last = 1;
    m_op = 4'd0; m_vec = '0; m_grant = 2'b00; m_err = 0; m_cnt = '0;
  endtask

  // Advance one clock edge and apply the same edge to the model
  task automatic tick();
    bit a0, a1;
    int idx;
    logic [3:0] o, f;
    logic [63:0] vv;
    a0 = m_ready(0);
    a1 = m_ready(1);
    idx = a1 ? 1 : 0;
    o = (idx == 1) ? op1 : op0;
    vv = (idx == 1) ? vec1 : vec0;
    @(posedge clk);
    if (!stall) begin
      if (a0 || a1) begin
        f = o;
        if (o > 4'd8) begin
          f = 4'd0; m_err = 1;
        end else if (o == 4'd6) begin
          if (m_depth < SD) begin
            m_depth++; m_locked = 1; m_owner = idx;
          end else begin
            f = 4'd0; m_err = 1;
          end
        end else if (o == 4'd7) begin
          if (m_depth > 0) begin
            m_depth--;
            if (m_depth == 0) m_locked = 0;
          end else begin
            f = 4'd0; m_err = 1;
          end
        end else if (o == 4'd1) begin
          m_cnt = m_cnt + 32'd1;
        end
        m_op = f; m_vec = vv; m_last = idx;
        m_grant = (idx == 1) ? 2'b10 : 2'b01;
      end else begin
        m_op = 4'd0;
        m_grant = m_locked ? ((m_owner == 1) ? 2'b10 : 2'b01) : 2'b00;
      end
    end
    #1;
  endtask

  task automatic apply_reset();
    v0 = 0; v1 = 0; stall = 0;
    rst_n = 0;
    model_reset();
    #3;
    rst_n = 1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    apply_reset();
    n_tests += 7;
    if (op_o !== 4'd0) begin n_fail++; $display("FAIL reset_op: got %0h want 0", op_o); end
    if (vec_o !== 64'd0) begin n_fail++; $display("FAIL reset_vec: got %0h want 0", vec_o); end
    if (grant_o !== 2'b00) begin n_fail++; $display("FAIL reset_grant: got %b want 00", grant_o); end
    if (locked_o !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b want 0", locked_o); end
    if (depth_o !== 5'd0) begin n_fail++; $display("FAIL reset_depth: got %0d want 0", depth_o); end
    if (err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err_o); end
    if (cnt_o !== 32'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", cnt_o); end
  endtask

  task automatic test_round_robin();
    logic [63:0] want;
    apply_reset();
    v0 = 1; v1 = 1; op0 = 4'd1; op1 = 4'd1;
    for (int k = 0; k < 4; k++) begin
      vec0 = {$urandom, $urandom};
      vec1 = {$urandom, $urandom};
      want = (k % 2 == 1) ? vec1 : vec0;
      #1;
      n_tests++;
      if ({r1, r0} !== ((k % 2 == 1) ? 2'b10 : 2'b01)) begin
        n_fail++; $display("FAIL rr_ready[%0d]: got %b want %b", k, {r1, r0},
                           (k % 2 == 1) ? 2'b10 : 2'b01);
      end
      tick();
      n_tests += 2;
      if (op_o !== 4'd1) begin n_fail++; $display("FAIL rr_op[%0d]: got %0h want 1", k, op_o); end
      if (vec_o !== want) begin
        n_fail++; $display("FAIL rr_vec[%0d]: got %0h want %0h", k, vec_o, want);
      end
    end
    v0 = 0; v1 = 0;
    n_tests++;
    if (cnt_o !== (CNT_EN ? 32'd4 : 32'd0)) begin
      n_fail++; $display("FAIL rr_count: got %0d want %0d", cnt_o, CNT_EN ? 4 : 0);
    end
  endtask

  task automatic test_lock();
    logic [3:0] seq [4];
    seq[0] = 4'd6; seq[1] = 4'd4; seq[2] = 4'd1; seq[3] = 4'd7;
    apply_reset();
    // Serve REQ0 once so REQ1 is favoured when the lock sequence starts
    v0 = 1; op0 = 4'd1; vec0 = {$urandom, $urandom};
    #1; tick();
    v1 = 1;
    for (int k = 0; k < 4; k++) begin
      op1 = seq[k];
      vec1 = (k == 1) ? 64'd5 : {$urandom, $urandom};
      #1;
      n_tests += 2;
      if (r0 !== 1'b0) begin n_fail++; $display("FAIL lock_r0[%0d]: got %b want 0", k, r0); end
      if (r1 !== 1'b1) begin n_fail++; $display("FAIL lock_r1[%0d]: got %b want 1", k, r1); end
      tick();
      n_tests += 3;
      if (op_o !== seq[k]) begin
        n_fail++; $display("FAIL lock_op[%0d]: got %0h want %0h", k, op_o, seq[k]);
      end
      if (locked_o !== (k < 3)) begin
        n_fail++; $display("FAIL lock_locked[%0d]: got %b want %b", k, locked_o, k < 3);
      end
      if (depth_o !== ((k < 3) ? 5'd1 : 5'd0)) begin
        n_fail++; $display("FAIL lock_depth[%0d]: got %0d want %0d", k, depth_o, k < 3);
      end
      if (k == 1) begin
        n_tests++;
        if (vec_o !== 64'd5) begin n_fail++; $display("FAIL lock_vec: got %0h want 5", vec_o); end
      end
    end
    v1 = 0;
    #1;
    n_tests++;
    if (r0 !== 1'b1) begin n_fail++; $display("FAIL lock_release_r0: got %b want 1", r0); end
    tick();
    n_tests++;
    if (grant_o !== 2'b01) begin
      n_fail++; $display("FAIL lock_release_grant: got %b want 01", grant_o);
    end
    v0 = 0;
  endtask

  task automatic test_overflow();
    apply_reset();
    v0 = 1; op0 = 4'd6;
    for (int k = 1; k <= 17; k++) begin
      vec0 = 64'(k);
      #1; tick();
      n_tests += 3;
      if (depth_o !== 5'((k <= SD) ? k : SD)) begin
        n_fail++; $display("FAIL ovf_depth[%0d]: got %0d want %0d", k, depth_o,
                           (k <= SD) ? k : SD);
      end
      if (op_o !== ((k <= SD) ? 4'd6 : 4'd0)) begin
        n_fail++; $display("FAIL ovf_op[%0d]: got %0h want %0h", k, op_o, (k <= SD) ? 6 : 0);
      end
      if (err_o !== (k > SD)) begin
        n_fail++; $display("FAIL ovf_err[%0d]: got %b want %b", k, err_o, k > SD);
      end
    end
    v0 = 0;
  endtask

  task automatic test_underflow_illegal();
    apply_reset();
    v0 = 1; op0 = 4'd7; vec0 = 64'h77;
    #1; tick();
    n_tests += 3;
    if (op_o !== 4'd0) begin n_fail++; $display("FAIL unf_op: got %0h want 0", op_o); end
    if (err_o !== 1'b1) begin n_fail++; $display("FAIL unf_err: got %b want 1", err_o); end
    if (locked_o !== 1'b0) begin n_fail++; $display("FAIL unf_locked: got %b want 0", locked_o); end
    apply_reset();
    v0 = 1; op0 = 4'd12;
    #1; tick();
    n_tests += 2;
    if (op_o !== 4'd0) begin n_fail++; $display("FAIL illegal_op: got %0h want 0", op_o); end
    if (err_o !== 1'b1) begin n_fail++; $display("FAIL illegal_err: got %b want 1", err_o); end
    v0 = 0;
  endtask

  task automatic test_stall();
    logic [63:0] a, b;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    apply_reset();
    v0 = 1; op0 = 4'd2; vec0 = a;
    #1; tick();
    op0 = 4'd1; vec0 = b; stall = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_tests++;
      if (r0 !== 1'b0) begin n_fail++; $display("FAIL stall_ready[%0d]: got %b want 0", k, r0); end
      tick();
      n_tests += 2;
      if (op_o !== 4'd2) begin n_fail++; $display("FAIL stall_op[%0d]: got %0h want 2", k, op_o); end
      if (vec_o !== a) begin
        n_fail++; $display("FAIL stall_vec[%0d]: got %0h want %0h", k, vec_o, a);
      end
    end
    stall = 0;
    #1;
    n_tests++;
    if (r0 !== 1'b1) begin n_fail++; $display("FAIL unstall_ready: got %b want 1", r0); end
    tick();
    n_tests += 2;
    if (op_o !== 4'd1) begin n_fail++; $display("FAIL unstall_op: got %0h want 1", op_o); end
    if (vec_o !== b) begin n_fail++; $display("FAIL unstall_vec: got %0h want %0h", vec_o, b); end
    v0 = 0;
  endtask

  task automatic test_reset_mid_lock();
    apply_reset();
    v1 = 1; op1 = 4'd6; vec1 = {$urandom, $urandom};
    #1; tick(); tick();
    n_tests += 2;
    if (depth_o !== 5'd2) begin n_fail++; $display("FAIL midlock_depth: got %0d want 2", depth_o); end
    if (locked_o !== 1'b1) begin n_fail++; $display("FAIL midlock_locked: got %b want 1", locked_o); end
    v1 = 0;
    #2; rst_n = 0; model_reset();
    #1;
    n_tests += 5;
    if (op_o !== 4'd0) begin n_fail++; $display("FAIL arst_op: got %0h want 0", op_o); end
    if (vec_o !== 64'd0) begin n_fail++; $display("FAIL arst_vec: got %0h want 0", vec_o); end
    if (grant_o !== 2'b00) begin n_fail++; $display("FAIL arst_grant: got %b want 00", grant_o); end
    if (locked_o !== 1'b0) begin n_fail++; $display("FAIL arst_locked: got %b want 0", locked_o); end
    if (depth_o !== 5'd0) begin n_fail++; $display("FAIL arst_depth: got %0d want 0", depth_o); end
    #2; rst_n = 1;
    v1 = 1; op1 = 4'd1;
    #1;
    n_tests++;
    if ({r1, r0} !== 2'b10) begin
      n_fail++; $display("FAIL arst_regrant: got %b want 10", {r1, r0});
    end
    tick();
    v1 = 0;
  endtask

  task automatic test_random();
    int r;
    apply_reset();
    for (int k = 0; k < 400; k++) begin
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      r = int'($urandom_range(0, 9));
      op0 = (r < 3) ? 4'd6 : (r < 6) ? 4'd7 : 4'($urandom_range(0, 15));
      r = int'($urandom_range(0, 9));
      op1 = (r < 3) ? 4'd6 : (r < 6) ? 4'd7 : 4'($urandom_range(0, 15));
      vec0 = {$urandom, $urandom};
      vec1 = {$urandom, $urandom};
      stall = ($urandom_range(0, 4) == 0);
      #1;
      n_tests++;
      if ({r1, r0} !== {m_ready(1), m_ready(0)}) begin
        n_fail++; $display("FAIL rnd_ready[%0d]: got %b want %b", k, {r1, r0},
                           {m_ready(1), m_ready(0)});
      end
      tick();
      n_tests++;
      if ({op_o, vec_o, grant_o, locked_o, depth_o, err_o} !==
          {m_op, m_vec, m_grant, m_locked, 5'(m_depth), m_err}) begin
        n_fail++;
        $display("FAIL rnd_state[%0d]: got op=%0h vec=%0h g=%b l=%b d=%0d e=%b want op=%0h vec=%0h g=%b l=%b d=%0d e=%b",
                 k, op_o, vec_o, grant_o, locked_o, depth_o, err_o,
                 m_op, m_vec, m_grant, m_locked, m_depth, m_err);
      end
      n_tests++;
      if (cnt_o !== (CNT_EN ? m_cnt : 32'd0)) begin
        n_fail++; $display("FAIL rnd_count[%0d]: got %0d want %0d", k, cnt_o,
                           CNT_EN ? m_cnt : 32'd0);
      end
    end
    v0 = 0; v1 = 0; stall = 0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_round_robin();
    test_lock();
    test_overflow();
    test_underflow_illegal();
    test_stall();
    test_reset_mid_lock();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
